// File: rtl/maxpool_nd_if.sv
// Handshake and data bundle between an upstream producer, maxpool_nd and
// the downstream consumer.
interface maxpool_nd_if #(
    parameter int BITWIDTH = 32,
    parameter int CHANNELS = 2,
    parameter int IN_H     = 28,
    parameter int IN_W     = 28,
    parameter int POOL     = 2
);
    localparam int OUT_H    = IN_H / POOL;
    localparam int OUT_W    = IN_W / POOL;
    localparam int IN_BITS  = CHANNELS * IN_H * IN_W * BITWIDTH;
    localparam int OUT_BITS = CHANNELS * OUT_H * OUT_W * BITWIDTH;

    logic                enable;
    logic [IN_BITS-1:0]  featuremap_in;
    logic                reply_from_next_device;
    logic [OUT_BITS-1:0] featuremap_out;
    logic                finished_for_next_device;
    logic                reply_to_last_device;

    modport master (
        output enable,
        output featuremap_in,
        output reply_from_next_device,
        input  featuremap_out,
        input  finished_for_next_device,
        input  reply_to_last_device
    );

    modport slave (
        input  enable,
        input  featuremap_in,
        input  reply_from_next_device,
        output featuremap_out,
        output finished_for_next_device,
        output reply_to_last_device
    );
endinterface

// File: rtl/maxpool_nd.sv
// Multi-channel POOLxPOOL max pooling: captures a whole feature map, pools
// one channel per cycle and holds the result until downstream consumes it.
module maxpool_nd #(
    parameter int BITWIDTH    = 32,
    parameter int CHANNELS    = 2,
    parameter int IN_H        = 28,
    parameter int IN_W        = 28,
    parameter int POOL        = 2,
    parameter int SIGNED_MODE = 0
) (
    input  logic         clk,
    input  logic         reset,
    maxpool_nd_if.slave  bus
);
    localparam int OUT_H  = IN_H / POOL;
    localparam int OUT_W  = IN_W / POOL;
    localparam int CH_IN  = IN_H * IN_W * BITWIDTH;
    localparam int CH_OUT = OUT_H * OUT_W * BITWIDTH;
    localparam int CW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_POOL,
        S_DONE
    } state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic [CW-1:0]              r_ch;
    logic [CHANNELS*CH_IN-1:0]  r_in;
    logic [CH_OUT-1:0]          r_out [CHANNELS];
    logic [CH_IN-1:0]           w_ch_arr [CHANNELS];
    logic [CH_IN-1:0]           w_ch_in;
    logic [CH_OUT-1:0]          w_pooled;

    function automatic logic f_gt(input logic [BITWIDTH-1:0] a,
                                  input logic [BITWIDTH-1:0] b);
        if (SIGNED_MODE != 0)
            return $signed(a) > $signed(b);
        return a > b;
    endfunction

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        assign w_ch_arr[g] = r_in[g*CH_IN +: CH_IN];
        assign bus.featuremap_out[g*CH_OUT +: CH_OUT] = r_out[g];
    end

    assign w_ch_in = w_ch_arr[r_ch];

    // Rows/columns past OUT_H*POOL / OUT_W*POOL never enter a window.
    for (genvar orr = 0; orr < OUT_H; orr++) begin : g_row
        for (genvar oc = 0; oc < OUT_W; oc++) begin : g_col
            logic [BITWIDTH-1:0] w_max;
            logic [BITWIDTH-1:0] w_cand;
            always_comb begin
                w_max  = w_ch_in[(oc*POOL*IN_H + orr*POOL)*BITWIDTH +: BITWIDTH];
                w_cand = w_max;
                for (int j = 0; j < POOL; j++) begin
                    for (int i = 0; i < POOL; i++) begin
                        w_cand = w_ch_in[((oc*POOL + j)*IN_H + orr*POOL + i)*BITWIDTH +: BITWIDTH];
                        if (f_gt(w_cand, w_max))
                            w_max = w_cand;
                    end
                end
            end
            assign w_pooled[(oc*OUT_H + orr)*BITWIDTH +: BITWIDTH] = w_max;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (bus.enable) w_next = S_READ;
            S_READ: w_next = S_POOL;
            S_POOL: if (r_ch == CW'(CHANNELS-1)) w_next = S_DONE;
            S_DONE: begin
                if (bus.reply_from_next_device)
                    w_next = bus.enable ? S_READ : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ch    <= '0;
            r_in    <= '0;
            for (int k = 0; k < CHANNELS; k++)
                r_out[k] <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_READ) begin
                r_in <= bus.featuremap_in;
                r_ch <= '0;
            end
            if (r_state == S_POOL) begin
                for (int k = 0; k < CHANNELS; k++)
                    if (r_ch == CW'(k))
                        r_out[k] <= w_pooled;
                r_ch <= (r_ch == CW'(CHANNELS-1)) ? '0 : r_ch + 1'b1;
            end
        end
    end

    assign bus.finished_for_next_device = (r_state == S_DONE);
    assign bus.reply_to_last_device     = (r_state == S_READ);
endmodule
